soc_dbus: RTL and testbench
===========================

SOC_DBUS -- requirements
Module: soc_dbus

Interface
REQ-001 SHALL have parameter N_SLV, default 4: number of data-bus slaves, range 1..8.
REQ-002 SHALL have parameter SLV_BASE, default {32'h3000_0000,32'h2000_0000,32'h1000_0000,32'h0000_0000}: packed N_SLV x 32 base addresses, slave 0 in the LSBs.
REQ-003 SHALL have parameter SLV_MASK, default {32'hFFFF_FF00,32'hFFFF_FF00,32'hFFFF_F000,32'hFFFF_0000}: packed N_SLV x 32 decode masks.
REQ-004 SHALL have parameter SLV_WAIT, default 16'h3210: packed N_SLV x 4 wait-state counts, 0..15 each.
REQ-005 SHALL have ports, one clock, synchronous active-high reset:
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  data_addr_i  in  32  CPU data address
  data_i  in  32  CPU write data
  data_we_i  in  1  CPU write request
  data_re_i  in  1  CPU read request
  data_size_i  in  3  access size, passed through
  data_o  out  32  read data to CPU
  stall_o  out  1  CPU hold request
  err_o  out  1  unmapped-access pulse
  s_sel_o  out  N_SLV  one-hot slave select
  s_addr_o  out  32  latched address
  s_wdata_o  out  32  latched write data
  s_we_o  out  1  slave write strobe
  s_re_o  out  1  slave read strobe
  s_size_o  out  3  latched size
  s_rdata_i  in  N_SLV*32  packed slave read data

Function
REQ-006 SHALL implement FSM states IDLE, ACCESS, DONE, ERR.
REQ-007 SHALL treat req = data_we_i | data_re_i; when both set, SHALL perform a write only.
REQ-008 SHALL decode slave i when (data_addr_i & mask_i) == (base_i & mask_i); lowest matching index wins.
REQ-009 IDLE with req and a match: latch address, write data, size, direction and slave index; load counter with that slave's wait; go ACCESS.
REQ-010 IDLE with req and no match: go ERR; no slave strobe asserted.
REQ-011 ACCESS: s_sel_o one-hot on latched index; s_re_o held high for reads; counter decrements each cycle; when counter==0, go DONE.
REQ-012 s_we_o SHALL be high only in the final ACCESS cycle (counter==0); exactly one write pulse per write.
REQ-013 On the final ACCESS cycle of a read, data_o SHALL register s_rdata_i[32*idx +: 32].
REQ-014 DONE and ERR SHALL last one cycle, ignore req and return to IDLE.
REQ-015 stall_o SHALL be combinational: 1 in IDLE with req, 1 in ACCESS, else 0.
REQ-016 err_o SHALL be 1 only in ERR; ERR SHALL load data_o with 0; the unmapped write is dropped.
REQ-017 data_o SHALL hold its last value across writes and idle cycles.
REQ-018 Latency: request seen in IDLE at cycle T, wait W -> ACCESS T+1..T+1+W, DONE at T+2+W; stall_o high T..T+1+W.
REQ-019 s_sel_o, s_we_o and s_re_o SHALL be 0 outside ACCESS; s_addr_o, s_wdata_o and s_size_o SHALL show the latched values.

Reset
REQ-020 rst at any edge, including mid-ACCESS, SHALL force IDLE, counter 0, data_o 0, all latches 0; err_o, s_sel_o, s_we_o and s_re_o SHALL be 0 the following cycle.
REQ-021 An access aborted by reset SHALL produce no further strobe; the CPU request still present after reset SHALL be treated as new.

Verification
REQ-022 Read 0x0000_0010, slave 0 data 0xDEAD_BEEF -> stall_o 2 cycles, DONE one cycle later, data_o=0xDEAD_BEEF.
REQ-023 Write 0x3000_0004 data 0x1234_5678 size 3'b010 -> s_sel_o=4'b1000, s_re_o low, s_we_o one pulse in 4th ACCESS cycle, stall_o 5 cycles.
REQ-024 Read 0x4000_0000 -> ERR next cycle, err_o one pulse, data_o=0, no s_sel_o activity.
REQ-025 Back-to-back reads to slave 1 then slave 2 held by CPU -> each request launched exactly once, DONE separates them.
REQ-026 rst asserted in 2nd ACCESS cycle of slave 3 write -> no s_we_o pulse, IDLE, all outputs 0 the following cycle.
REQ-027 data_we_i and data_re_i both high to slave 0 -> write pulse only, data_o unchanged.

Source files
------------

// File: rtl/soc_dbus.sv
// rtl/soc_dbus.sv - CPU data-bus bridge: address decode, per-slave wait states, read-data return.
// One access at a time: IDLE -> ACCESS (wait+1 cycles) -> DONE, or IDLE -> ERR for unmapped addresses.
module soc_dbus #(
  parameter int                  N_SLV    = 4,
  parameter logic [N_SLV*32-1:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [N_SLV*32-1:0] SLV_MASK = {32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_F000, 32'hFFFF_0000},
  parameter logic [N_SLV*4-1:0]  SLV_WAIT = 16'h3210
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         data_addr_i,
  input  logic [31:0]         data_i,
  input  logic                data_we_i,
  input  logic                data_re_i,
  input  logic [2:0]          data_size_i,
  output logic [31:0]         data_o,
  output logic                stall_o,
  output logic                err_o,
  output logic [N_SLV-1:0]    s_sel_o,
  output logic [31:0]         s_addr_o,
  output logic [31:0]         s_wdata_o,
  output logic                s_we_o,
  output logic                s_re_o,
  output logic [2:0]          s_size_o,
  input  logic [N_SLV*32-1:0] s_rdata_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [2:0]  idx;
  logic        dir_we;
  logic        req;
  logic        hit;
  logic [2:0]  hit_idx;
  logic [3:0]  hit_wait;
  logic [31:0] rdata_sel;

  assign req = data_we_i | data_re_i;

  // Lowest matching index wins, so later matches are ignored once hit is set.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_wait = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (!hit && ((data_addr_i & SLV_MASK[32*i +: 32]) ==
                   (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32]))) begin
        hit      = 1'b1;
        hit_idx  = 3'(i);
        hit_wait = SLV_WAIT[4*i +: 4];
      end
    end
  end

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (idx == 3'(i)) rdata_sel = s_rdata_i[32*i +: 32];
    end
  end

  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    err_o     = 1'b0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    s_re_o    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          stall_o   = 1'b1;
          state_nxt = hit ? ACCESS : ERR;
        end
      end
      ACCESS: begin
        stall_o = 1'b1;
        s_sel_o = N_SLV'(1) << idx;
        s_re_o  = !dir_we;
        s_we_o  = dir_we && (cnt == 4'd0);
        if (cnt == 4'd0) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      ERR: begin
        err_o     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      dir_we    <= 1'b0;
      data_o    <= '0;
      s_addr_o  <= '0;
      s_wdata_o <= '0;
      s_size_o  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req && hit) begin
            idx       <= hit_idx;
            dir_we    <= data_we_i;
            cnt       <= hit_wait;
            s_addr_o  <= data_addr_i;
            s_wdata_o <= data_i;
            s_size_o  <= data_size_i;
          end else if (req) begin
            data_o <= '0;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!dir_we) data_o <= rdata_sel;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_dbus.sv
// tb/tb_soc_dbus.sv - directed bench for soc_dbus with a per-cycle timeline model.
// The model schedules each accepted access as ACCESS cycles T+1..T+1+W and DONE at T+2+W.
module tb_soc_dbus;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   addr, wdata;
  logic          we, re;
  logic [2:0]    size;
  logic [31:0]   rdata;
  logic          stall, err;
  logic [3:0]    sel;
  logic [31:0]   s_addr, s_wdata;
  logic          s_we, s_re;
  logic [2:0]    s_size;
  logic [127:0]  s_rdata;

  localparam logic [31:0] BASE [4] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
  localparam logic [31:0] MASK [4] = '{32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_FF00, 32'hFFFF_FF00};
  localparam int          WAITS [4] = '{0, 1, 2, 3};
  localparam logic [31:0] RD [4]   = '{32'hDEAD_BEEF, 32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003};

  int n_chk = 0;
  int n_fail = 0;

  soc_dbus dut (
    .clk(clk), .rst(rst),
    .data_addr_i(addr), .data_i(wdata), .data_we_i(we), .data_re_i(re), .data_size_i(size),
    .data_o(rdata), .stall_o(stall), .err_o(err),
    .s_sel_o(sel), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_we_o(s_we), .s_re_o(s_re),
    .s_size_o(s_size), .s_rdata_i(s_rdata)
  );

  always #5 clk = ~clk;
  assign s_rdata = {RD[3], RD[2], RD[1], RD[0]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void decode(input logic [31:0] a, output bit h, output int s);
    h = 0;
    s = 0;
    for (int i = 3; i >= 0; i--) begin
      if ((a & MASK[i]) == (BASE[i] & MASK[i])) begin
        h = 1;
        s = i;
      end
    end
  endfunction

  // Timeline model: compare this cycle's outputs, then schedule the effect of the coming edge.
  initial begin : model
    bit          started = 0;
    bit          busy = 0;
    int          cyc = 0, t0 = 0, w = 0, err_at = -1, m_idx = 0;
    bit          m_we = 0;
    logic [31:0] m_data = '0, m_addr = '0, m_wdata = '0;
    logic [2:0]  m_size = '0;
    bit          acc, done, errc, idle, h;
    int          s;
    forever begin
      @(negedge clk);
      acc  = busy && (cyc > t0) && (cyc <= t0 + 1 + w);
      done = busy && (cyc == t0 + 2 + w);
      errc = (cyc == err_at);
      idle = !(acc || done || errc);
      if (started) begin
        chk("stall", 32'(stall), 32'((idle && (we || re)) || acc));
        chk("err", 32'(err), 32'(errc));
        chk("sel", 32'(sel), acc ? 32'(4'b1 << m_idx) : 32'd0);
        chk("s_re", 32'(s_re), 32'(acc && !m_we));
        chk("s_we", 32'(s_we), 32'(acc && m_we && (cyc == t0 + 1 + w)));
        chk("data", rdata, m_data);
        chk("s_addr", s_addr, m_addr);
        chk("s_wdata", s_wdata, m_wdata);
        chk("s_size", 32'(s_size), 32'(m_size));
      end
      if (rst) begin
        started = 1;
        busy = 0;
        err_at = -1;
        m_data = '0; m_addr = '0; m_wdata = '0; m_size = '0; m_we = 0; m_idx = 0;
      end else if (started) begin
        if (acc && (cyc == t0 + 1 + w) && !m_we) m_data = RD[m_idx];
        if (done) busy = 0;
        if (idle && (we || re)) begin
          decode(addr, h, s);
          if (h) begin
            busy = 1; t0 = cyc; w = WAITS[s]; m_idx = s; m_we = we;
            m_addr = addr; m_wdata = wdata; m_size = size;
          end else begin
            err_at = cyc + 1;
            m_data = '0;
          end
        end
      end
      cyc++;
    end
  end

  int         stall_n, we_n, re_n, err_n, acc_n, we_at;
  int         selc [4];
  logic [3:0] sel_or;
  logic [31:0] prev;

  task automatic start(input logic [31:0] a, input logic [31:0] d, input logic w_, input logic r_,
                       input logic [2:0] sz);
    addr = a; wdata = d; we = w_; re = r_; size = sz;
  endtask

  task automatic idle_bus();
    we = 0; re = 0;
  endtask

  // Observe from the request cycle until stall drops (DONE/ERR), then step past that edge.
  task automatic wait_done();
    bit to = 1;
    stall_n = 0; we_n = 0; re_n = 0; err_n = 0; acc_n = 0; we_at = 0; sel_or = '0;
    for (int j = 0; j < 4; j++) selc[j] = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      stall_n += int'(stall); we_n += int'(s_we); re_n += int'(s_re); err_n += int'(err);
      sel_or |= sel;
      if (|sel) acc_n++;
      if (s_we && we_at == 0) we_at = acc_n;
      for (int j = 0; j < 4; j++) selc[j] += int'(sel[j]);
      if (!stall) begin
        to = 0;
        break;
      end
    end
    chk("txn_timeout", 32'(to), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int we_seen;
    rst = 1; addr = '0; wdata = '0; we = 0; re = 0; size = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_data", rdata, 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;

    // Read slave 0, zero wait states
    start(32'h0000_0010, 32'h0, 0, 1, 3'b010);
    wait_done();
    idle_bus();
    chk("r0_stall_cycles", 32'(stall_n), 32'd2);
    chk("r0_data", rdata, 32'hDEAD_BEEF);
    chk("r0_we_pulses", 32'(we_n), 32'd0);
    @(posedge clk); #1;

    // Write slave 3, three wait states
    start(32'h3000_0004, 32'h1234_5678, 1, 0, 3'b010);
    wait_done();
    idle_bus();
    chk("w3_sel", 32'(sel_or), 32'h8);
    chk("w3_re_cycles", 32'(re_n), 32'd0);
    chk("w3_we_pulses", 32'(we_n), 32'd1);
    chk("w3_we_slot", 32'(we_at), 32'd4);
    chk("w3_stall_cycles", 32'(stall_n), 32'd5);
    chk("w3_wdata", s_wdata, 32'h1234_5678);
    chk("w3_data_kept", rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // Unmapped read
    start(32'h4000_0000, 32'h0, 0, 1, 3'b010);
    wait_done();
    idle_bus();
    chk("ue_err_pulses", 32'(err_n), 32'd1);
    chk("ue_sel", 32'(sel_or), 32'd0);
    chk("ue_data", rdata, 32'd0);
    chk("ue_stall_cycles", 32'(stall_n), 32'd1);
    @(posedge clk); #1;

    // Back-to-back reads, request held through DONE
    start(32'h1000_0020, 32'h0, 0, 1, 3'b010);
    wait_done();
    chk("b1_sel_cycles", 32'(selc[1]), 32'd2);
    chk("b1_data", rdata, 32'hA1A1_0001);
    start(32'h2000_0010, 32'h0, 0, 1, 3'b010);
    wait_done();
    idle_bus();
    chk("b2_sel_cycles", 32'(selc[2]), 32'd3);
    chk("b2_sel_other", 32'(selc[1]), 32'd0);
    chk("b2_data", rdata, 32'hB2B2_0002);
    @(posedge clk); #1;

    // Write and read together: write wins
    prev = rdata;
    start(32'h0000_0040, 32'h55AA_55AA, 1, 1, 3'b001);
    wait_done();
    idle_bus();
    chk("wr_we_pulses", 32'(we_n), 32'd1);
    chk("wr_re_cycles", 32'(re_n), 32'd0);
    chk("wr_data_kept", rdata, prev);
    @(posedge clk); #1;

    // Reset in the second ACCESS cycle of a slave 3 write
    we_seen = 0;
    start(32'h3000_0004, 32'hCAFE_F00D, 1, 0, 3'b010);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      we_seen += int'(s_we);
      @(posedge clk); #1;
    end
    rst = 1;
    idle_bus();
    @(negedge clk);
    we_seen += int'(s_we);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("ra_we_seen", 32'(we_seen), 32'd0);
    chk("ra_outs", {26'd0, stall, err, sel}, 32'd0);
    chk("ra_strobes", {30'd0, s_we, s_re}, 32'd0);
    chk("ra_data", rdata, 32'd0);
    chk("ra_latches", s_addr | s_wdata | 32'(s_size), 32'd0);
    repeat (4) @(negedge clk) we_seen += int'(s_we);
    chk("ra_no_late_we", 32'(we_seen), 32'd0);
    @(posedge clk); #1;

    // Reset mid-read with the request still held: relaunched as new
    start(32'h2000_0004, 32'h0, 0, 1, 3'b010);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    wait_done();
    idle_bus();
    chk("rh_stall_cycles", 32'(stall_n), 32'd4);
    chk("rh_sel_cycles", 32'(selc[2]), 32'd3);
    chk("rh_data", rdata, 32'hB2B2_0002);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
